// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU: latches decoded operands and
// control, forwards from MEM/WB, and flags load-use hazards back to ID.
module id_ex_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic [RA-1:0]    rs_d,
  input  logic [RA-1:0]    rt_d,
  input  logic [RA-1:0]    rd_d,
  input  logic [2:0]       alucontrol_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic [WIDTH-1:0] aluout_m,
  input  logic             regwrite_m,
  input  logic [RA-1:0]    writereg_m,
  input  logic [WIDTH-1:0] result_w,
  input  logic             regwrite_w,
  input  logic [RA-1:0]    writereg_w,
  output logic [WIDTH-1:0] srca_e,
  output logic [WIDTH-1:0] srcb_e,
  output logic [2:0]       alucontrol_e,
  output logic [WIDTH-1:0] writedata_e,
  output logic [RA-1:0]    writereg_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic             memwrite_e,
  output logic             valid_e,
  output logic             lwstall_d
);

  logic             valid_q, regwrite_q, memtoreg_q, memwrite_q;
  logic             alusrc_q, regdst_q;
  logic [2:0]       alucontrol_q;
  logic [WIDTH-1:0] rd1_q, rd2_q, signimm_q;
  logic [RA-1:0]    rs_q, rt_q, rd_q;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  // Priority: reset > flush > stall > load. A flush zeroes only control and
  // register numbers so the bubble can neither write nor match a forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      alusrc_q     <= 1'b0;
      regdst_q     <= 1'b0;
      alucontrol_q <= 3'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      signimm_q    <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
    end else if (flush_e) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else if (!stall_e) begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d & valid_d;
      memtoreg_q   <= memtoreg_d & valid_d;
      memwrite_q   <= memwrite_d & valid_d;
      alusrc_q     <= alusrc_d;
      regdst_q     <= regdst_d;
      alucontrol_q <= alucontrol_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      signimm_q    <= signimm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
    end
  end

  // Forwarding muxes: MEM beats WB, register $0 is never forwarded.
  always_comb begin
    fwd_a = rd1_q;
    fwd_b = rd2_q;
    if (rs_q != '0 && regwrite_m && writereg_m == rs_q)      fwd_a = aluout_m;
    else if (rs_q != '0 && regwrite_w && writereg_w == rs_q) fwd_a = result_w;
    if (rt_q != '0 && regwrite_m && writereg_m == rt_q)      fwd_b = aluout_m;
    else if (rt_q != '0 && regwrite_w && writereg_w == rt_q) fwd_b = result_w;
  end

  assign srca_e       = fwd_a;
  assign srcb_e       = alusrc_q ? signimm_q : fwd_b;
  assign writedata_e  = fwd_b;
  assign writereg_e   = regdst_q ? rd_q : rt_q;
  assign alucontrol_e = alucontrol_q;
  assign regwrite_e   = regwrite_q;
  assign memtoreg_e   = memtoreg_q;
  assign memwrite_e   = memwrite_q;
  assign valid_e      = valid_q;

  assign lwstall_d = valid_q & memtoreg_q & (rt_q != '0) & ((rt_q == rs_d) | (rt_q == rt_d));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e, valid_d;
  logic [31:0] rd1_d, rd2_d, signimm_d, aluout_m, result_w;
  logic [4:0]  rs_d, rt_d, rd_d, writereg_m, writereg_w;
  logic [2:0]  alucontrol_d;
  logic        alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d;
  logic        regwrite_m, regwrite_w;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  writereg_e;
  logic        regwrite_e, memtoreg_e, memwrite_e, valid_e, lwstall_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.WIDTH(32), .RA(5)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d), .rs_d(rs_d), .rt_d(rt_d),
    .rd_d(rd_d), .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d), .regdst_d(regdst_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
    .aluout_m(aluout_m), .regwrite_m(regwrite_m), .writereg_m(writereg_m),
    .result_w(result_w), .regwrite_w(regwrite_w), .writereg_w(writereg_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e), .valid_e(valid_e),
    .lwstall_d(lwstall_d)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [2:0] f, input logic asrc,
                       input logic rdst, input logic rw, input logic m2r, input logic mw);
    valid_d = v; rd1_d = a; rd2_d = b; signimm_d = imm; rs_d = rs; rt_d = rt; rd_d = rd;
    alucontrol_d = f; alusrc_d = asrc; regdst_d = rdst;
    regwrite_d = rw; memtoreg_d = m2r; memwrite_d = mw;
  endtask

  task automatic quiet_mw();
    regwrite_m = 1'b0; writereg_m = 5'd0; aluout_m = 32'h0;
    regwrite_w = 1'b0; writereg_w = 5'd0; result_w = 32'h0;
  endtask

  task automatic test_reset();
    set_d(1'b1, 32'hDEAD, 32'hBEEF, 32'h1234, 5'd7, 5'd8, 5'd9, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    stall_e = 1'b1; flush_e = 1'b1;
    regwrite_m = 1'b1; writereg_m = 5'd3; aluout_m = 32'h55;
    regwrite_w = 1'b1; writereg_w = 5'd4; result_w = 32'h66;
    reset = 1'b1;
    step(); step();
    total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_e); end
    total++; if (regwrite_e !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", regwrite_e); end
    total++; if (memwrite_e !== 1'b0) begin bad++; $display("FAIL reset_memwrite got=%b exp=0", memwrite_e); end
    total++; if (memtoreg_e !== 1'b0) begin bad++; $display("FAIL reset_memtoreg got=%b exp=0", memtoreg_e); end
    total++; if (alucontrol_e !== 3'd0) begin bad++; $display("FAIL reset_alucontrol got=%0d exp=0", alucontrol_e); end
    total++; if (srca_e !== 32'h0) begin bad++; $display("FAIL reset_srca got=%h exp=0", srca_e); end
    total++; if (srcb_e !== 32'h0) begin bad++; $display("FAIL reset_srcb got=%h exp=0", srcb_e); end
    total++; if (writereg_e !== 5'd0) begin bad++; $display("FAIL reset_writereg got=%0d exp=0", writereg_e); end
    reset = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    quiet_mw();
  endtask

  task automatic test_plain_load();
    set_d(1'b1, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd9, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (srca_e !== 32'd5) begin bad++; $display("FAIL load_srca got=%h exp=%h", srca_e, 32'd5); end
    total++; if (srcb_e !== 32'd7) begin bad++; $display("FAIL load_srcb got=%h exp=%h", srcb_e, 32'd7); end
    total++; if (alucontrol_e !== 3'd2) begin bad++; $display("FAIL load_alucontrol got=%0d exp=2", alucontrol_e); end
    total++; if (writereg_e !== 5'd9) begin bad++; $display("FAIL load_writereg_rd got=%0d exp=9", writereg_e); end
    total++; if (valid_e !== 1'b1 || regwrite_e !== 1'b1) begin bad++; $display("FAIL load_ctrl got=%b%b exp=11", valid_e, regwrite_e); end
    set_d(1'b1, 32'd5, 32'd7, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd9, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (srcb_e !== 32'hFFFF_FFFC) begin bad++; $display("FAIL load_imm_srcb got=%h exp=fffffffc", srcb_e); end
    total++; if (writedata_e !== 32'd7) begin bad++; $display("FAIL load_imm_writedata got=%h exp=7", writedata_e); end
    total++; if (writereg_e !== 5'd2) begin bad++; $display("FAIL load_writereg_rt got=%0d exp=2", writereg_e); end
  endtask

  task automatic test_valid_gating();
    set_d(1'b0, 32'd1, 32'd2, 32'h0, 5'd1, 5'd2, 5'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL gate_valid got=%b exp=0", valid_e); end
    total++; if ({regwrite_e, memtoreg_e, memwrite_e} !== 3'b000) begin bad++; $display("FAIL gate_ctrl got=%b exp=000", {regwrite_e, memtoreg_e, memwrite_e}); end
  endtask

  task automatic test_forward();
    set_d(1'b1, 32'hAA, 32'hBB, 32'h0, 5'd3, 5'd5, 5'd6, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    regwrite_m = 1'b1; writereg_m = 5'd3; aluout_m = 32'h11;
    regwrite_w = 1'b1; writereg_w = 5'd3; result_w = 32'h22;
    #1;
    total++; if (srca_e !== 32'h11) begin bad++; $display("FAIL fwd_mem_prio got=%h exp=11", srca_e); end
    total++; if (srcb_e !== 32'hBB) begin bad++; $display("FAIL fwd_b_none got=%h exp=bb", srcb_e); end
    regwrite_m = 1'b0;
    #1;
    total++; if (srca_e !== 32'h22) begin bad++; $display("FAIL fwd_wb got=%h exp=22", srca_e); end
    writereg_w = 5'd5;
    #1;
    total++; if (srca_e !== 32'hAA) begin bad++; $display("FAIL fwd_a_none got=%h exp=aa", srca_e); end
    total++; if (srcb_e !== 32'h22 || writedata_e !== 32'h22) begin bad++; $display("FAIL fwd_b_wb got=%h/%h exp=22/22", srcb_e, writedata_e); end
    // Register $0 must read its latched value even when M targets $0.
    set_d(1'b1, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 5'd6, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    regwrite_m = 1'b1; writereg_m = 5'd0; aluout_m = 32'h11;
    regwrite_w = 1'b1; writereg_w = 5'd0;
    step();
    total++; if (srca_e !== 32'h33) begin bad++; $display("FAIL fwd_zero_a got=%h exp=33", srca_e); end
    total++; if (writedata_e !== 32'h44) begin bad++; $display("FAIL fwd_zero_b got=%h exp=44", writedata_e); end
    set_d(1'b1, 32'h1, 32'hBB, 32'h44, 5'd1, 5'd5, 5'd6, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    writereg_m = 5'd5; regwrite_w = 1'b0;
    step();
    total++; if (srcb_e !== 32'h44) begin bad++; $display("FAIL fwd_imm_srcb got=%h exp=44", srcb_e); end
    total++; if (writedata_e !== 32'h11) begin bad++; $display("FAIL fwd_store_data got=%h exp=11", writedata_e); end
    quiet_mw();
  endtask

  task automatic test_load_use();
    set_d(1'b1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd4, 5'd7, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    rs_d = 5'd4; rt_d = 5'd6;
    #1;
    total++; if (lwstall_d !== 1'b1) begin bad++; $display("FAIL lw_rs_match got=%b exp=1", lwstall_d); end
    rs_d = 5'd0; rt_d = 5'd4;
    #1;
    total++; if (lwstall_d !== 1'b1) begin bad++; $display("FAIL lw_rt_match got=%b exp=1", lwstall_d); end
    rs_d = 5'd1; rt_d = 5'd2;
    #1;
    total++; if (lwstall_d !== 1'b0) begin bad++; $display("FAIL lw_no_match got=%b exp=0", lwstall_d); end
    set_d(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    total++; if (lwstall_d !== 1'b0) begin bad++; $display("FAIL lw_rt_zero got=%b exp=0", lwstall_d); end
    set_d(1'b0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd4, 5'd7, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    total++; if (lwstall_d !== 1'b0) begin bad++; $display("FAIL lw_invalid got=%b exp=0", lwstall_d); end
  endtask

  task automatic test_stall_flush();
    set_d(1'b1, 32'h100, 32'h200, 32'h0, 5'd1, 5'd2, 5'd8, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(1'b0, 32'(i + 7), 32'(i + 9), 32'h0, 5'd3, 5'd4, 5'(i + 10), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      total++;
      if (srca_e !== 32'h100 || srcb_e !== 32'h200 || alucontrol_e !== 3'd5 || writereg_e !== 5'd8 ||
          valid_e !== 1'b1 || memwrite_e !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold_%0d got=%h %h %0d %0d %b%b exp=100 200 5 8 11", i, srca_e, srcb_e,
                 alucontrol_e, writereg_e, valid_e, memwrite_e);
      end
    end
    flush_e = 1'b1;
    step();
    total++; if ({valid_e, regwrite_e, memwrite_e} !== 3'b000) begin bad++; $display("FAIL flush_ctrl got=%b exp=000", {valid_e, regwrite_e, memwrite_e}); end
    total++; if (writereg_e !== 5'd0) begin bad++; $display("FAIL flush_writereg got=%0d exp=0", writereg_e); end
    flush_e = 1'b0; stall_e = 1'b0;
  endtask

  task automatic test_reset_during_stall();
    set_d(1'b1, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd3, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    stall_e = 1'b1; reset = 1'b1;
    step();
    total++;
    if ({valid_e, regwrite_e, memtoreg_e, memwrite_e} !== 4'b0000 || alucontrol_e !== 3'd0) begin
      bad++;
      $display("FAIL rst_stall_ctrl got=%b alu=%0d exp=0000 alu=0", {valid_e, regwrite_e, memtoreg_e, memwrite_e}, alucontrol_e);
    end
    total++; if (srca_e !== 32'h0) begin bad++; $display("FAIL rst_stall_srca got=%h exp=0", srca_e); end
    reset = 1'b0; stall_e = 1'b0;
    set_d(1'b1, 32'h77, 32'h6, 32'h0, 5'd1, 5'd2, 5'd3, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (valid_e !== 1'b1 || alucontrol_e !== 3'd3 || srca_e !== 32'h77) begin bad++; $display("FAIL rst_resume got=%b %0d %h exp=1 3 77", valid_e, alucontrol_e, srca_e); end
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    quiet_mw();
    set_d(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_plain_load();
    test_valid_gating();
    test_forward();
    test_load_use();
    test_stall_flush();
    test_reset_during_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
